serial_subtractor: RTL
======================

# serial_subtractor

Multi-cycle 32-bit subtractor for the CPU datapath. It computes `diff = a - b` a few bits per clock using a start/busy/done handshake. It also produces unsigned-borrow, zero and (optionally) signed-overflow flags. It sits beside the combinational adder in the execute stage and serves SUB/compare operations where area matters more than latency.

## Interface
- `WIDTH`, 32: operand and result width.
- `DIGIT`, 4: bits processed per cycle. Must divide `WIDTH` evenly. `N = WIDTH/DIGIT` gives the cycle count, 8 at defaults.
- `clk`, input, 1: the single clock. Everything updates on its rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `start`, input, 1: request strobe. Only sampled in IDLE or DONE.
- `a`, input, WIDTH: minuend. Only sampled on an accepted `start`.
- `b`, input, WIDTH: subtrahend. Only sampled on an accepted `start`.
- `busy`, output, 1: high while the operation is in progress (RUN).
- `done`, output, 1: single-cycle pulse when the result becomes valid.
- `diff`, output, WIDTH: `a - b` modulo 2^WIDTH. Held until the next accepted `start`.
- `borrow`, output, 1: 1 when `a < b` unsigned, i.e. the inverse of the final carry.
- `zero`, output, 1: 1 when `diff == 0`.
- `overflow`, output, 1: signed overflow of `a - b`. See Configuration.

## Operation
The block is a three-state FSM: IDLE, RUN, DONE.
- **IDLE, `start=1`:**
  - Latch `a` and `~b` into shift registers.
  - Set `carry=1`, because `a - b` is computed as `a + ~b + 1`.
  - Clear the digit counter and go to RUN.
- **RUN, each cycle:**
  - Add the low `DIGIT` bits of both shift registers plus `carry`.
  - Shift the `DIGIT`-bit sum into the top of the result register, so the LSB digit ends up at bit 0.
  - Shift both operand registers right by `DIGIT`, update `carry` and increment the counter.
  - When the counter reaches `N-1`:
    - go to DONE;
    - register `diff`, `borrow = ~carry_out`, `zero` and `overflow`.
- **DONE:**
  - `done=1` for exactly this cycle.
  - With `start=1` in this cycle: accept a new operation and go to RUN (back-to-back). Otherwise go to IDLE.
- **`start` during RUN:** ignored. `a` and `b` are not re-sampled.
- **Result holding:** `diff` and the flags are only updated at the end of RUN. They keep their values through IDLE and through the next operation's RUN cycles.
- **Overflow formula:** `overflow = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1])`, using the latched copy of `a`.

## Timing
- **Reset values:** `rst=1` forces IDLE with `busy=0`, `done=0`, `diff=0`, `borrow=0`, `zero=0`, `overflow=0`. The counter and shift registers are cleared.
- **Reset priority:** `rst` overrides `start` in the same cycle.
- **Reset mid-operation:** reset during RUN aborts the operation. No `done` is produced.
- **Latency:** with `start` accepted at edge k:
  - `busy=1` during the cycles following edges k through k+N-1;
  - `done=1` and the result valid in the cycle following edge k+N.
  - At the defaults this is 8 RUN cycles, with `done` 8 cycles after the accepting edge.
- **Throughput:** with `start` held high, one result every N+1 cycles.
- **Mutual exclusion:** `busy` and `done` are never high together.

## Configuration
- `SERIAL_SUBTRACTOR_OVERFLOW_EN`:
  - **Defined:** the overflow logic is built and `overflow` is registered as described above.
  - **Undefined:** the overflow logic is removed and `overflow` is tied to constant 0.
  - **Either way:** the port list and every other output are identical.

## Structure
- **Shared package `serial_subtractor_pkg`:**
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default `WIDTH` and `DIGIT` constants;
  - the `N` derivation.
- **Sub-module `sub_digit`:** a combinational `DIGIT`-bit adder slice. Inputs: digit of `a`, digit of `~b`, `carry_in`. Outputs: `sum` and `carry_out`. It is instantiated once and reused every RUN cycle.

## Test plan
- **Basic subtract:** `a=7`, `b=3` → after `done`: `diff=0x00000004`, `borrow=0`, `zero=0`, `overflow=0`. `busy` is high for exactly 8 cycles.
- **Negative result:** `a=3`, `b=7` → `diff=0xFFFFFFFC`, `borrow=1`, `zero=0`, `overflow=0`.
- **Signed overflow:** `a=0x80000000`, `b=1` → `diff=0x7FFFFFFF`, `borrow=0`. `overflow=1` with the macro defined, 0 without it.
- **Equal operands, then back-to-back:**
  - `a=b=0xDEADBEEF` → `diff=0`, `zero=1`, `borrow=0`.
  - `start=1` held into the DONE cycle with `a=0x10`, `b=0x1` → `diff=0xF` exactly 9 cycles later.
- **Start while busy:** `start` with `a=5`, `b=2`; pulse `start` with `a=0`, `b=0` in RUN cycle 3 → single `done` with `diff=3`. The second request is ignored.
- **Reset mid-operation:** assert `rst` in RUN cycle 4 → the next cycle is IDLE with all outputs 0. No `done` pulse follows.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the digit-serial subtractor.
// State encoding, default geometry and the cycle-count derivation live here.
package serial_subtractor_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of RUN cycles needed to consume a full operand.
    function automatic int calc_n(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit adder slice, reused by the serial subtractor every
// RUN cycle.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_dig,
    input  logic [DIGIT-1:0] b_inv_dig,
    input  logic             carry_in,
    output logic [DIGIT-1:0] sum,
    output logic             carry_out
);

    always_comb begin
        {carry_out, sum} = {1'b0, a_dig} + {1'b0, b_inv_dig} + {{DIGIT{1'b0}}, carry_in};
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b computed DIGIT bits per clock with a start/busy/done handshake.
// Optional signed-overflow flag is built when SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             overflow
);

    localparam int N  = calc_n(WIDTH, DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_sh_q, a_sh_d;
    logic [WIDTH-1:0]     b_sh_q, b_sh_d;
    logic [WIDTH-DIGIT-1:0] res_sh_q, res_sh_d;
    logic                 carry_q, carry_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     diff_q, diff_d;
    logic                 borrow_q, borrow_d;
    logic                 zero_q, zero_d;

    logic [DIGIT-1:0]     dig_sum;
    logic                 dig_carry;
    logic [WIDTH-1:0]     res_full;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    // Operand sign bits are kept separately because the shift registers lose them.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic overflow_q, overflow_d;
`endif

    sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
        .a_dig     (a_sh_q[DIGIT-1:0]),
        .b_inv_dig (b_sh_q[DIGIT-1:0]),
        .carry_in  (carry_q),
        .sum       (dig_sum),
        .carry_out (dig_carry)
    );

    assign res_full = {dig_sum, res_sh_q};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        overflow_d = overflow_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = ~b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                res_sh_d = res_full[WIDTH-1:DIGIT];
                carry_d  = dig_carry;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = ST_DONE;
                    diff_d   = res_full;
                    borrow_d = ~dig_carry;
                    zero_d   = (res_full == '0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    overflow_d = (a_msb_q != b_msb_q) & (res_full[WIDTH-1] != a_msb_q);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            overflow_q <= overflow_d;
`endif
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
